// File: rtl/layer_output_collector.sv
// Deserialises SIZE consecutive accepted words into one packed frame and presents it to the
// downstream consumer under a valid/ready handshake. Words offered while the collector cannot
// take them are discarded and tallied in a saturating counter.
module layer_output_collector #(
    parameter int unsigned SIZE     = 3,
    parameter int unsigned BIT_SIZE = 16,
    parameter int unsigned DROP_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BIT_SIZE-1:0]          y,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SIZE*BIT_SIZE-1:0]     out_data,
    output logic [DROP_W-1:0]            drop_cnt
);

    localparam int unsigned IdxW = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [0:0] {StCollect, StHold} state_e;

    state_e                      state_q, state_d;
    logic [IdxW-1:0]             idx_q, idx_d;
    logic [SIZE*BIT_SIZE-1:0]    data_q, data_d;
    logic [DROP_W-1:0]           drop_q, drop_d;

    // Handshake outputs derived straight from state; in_ready lets a word in during handoff.
    always_comb begin
        in_ready  = (state_q == StCollect) | ((state_q == StHold) & out_ready);
        out_valid = (state_q == StHold);
        out_data  = data_q;
        drop_cnt  = drop_q;
    end

    // Next-state: clear overrides everything, otherwise fill / hold / hand off and count drops.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        drop_d  = drop_q;

        if (clear) begin
            state_d = StCollect;
            idx_d   = '0;
            data_d  = '0;
            drop_d  = '0;
        end else begin
            if (in_valid && !in_ready && (drop_q != {DROP_W{1'b1}})) begin
                drop_d = drop_q + DROP_W'(1);
            end

            unique case (state_q)
                StCollect: begin
                    if (in_valid) begin
                        for (int k = 0; k < int'(SIZE); k++) begin
                            if (idx_q == IdxW'(k)) begin
                                data_d[k*BIT_SIZE +: BIT_SIZE] = y;
                            end
                        end
                        if (idx_q == IdxW'(SIZE - 1)) begin
                            idx_d   = '0;
                            state_d = StHold;
                        end else begin
                            idx_d = idx_q + IdxW'(1);
                        end
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        state_d = StCollect;
                        // A word arriving on the handoff edge becomes word 0 of the next frame.
                        if (in_valid) begin
                            data_d[0 +: BIT_SIZE] = y;
                            idx_d                 = IdxW'(1);
                        end else begin
                            idx_d = '0;
                        end
                    end
                end
                default: state_d = StCollect;
            endcase
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StCollect;
            idx_q   <= '0;
            data_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_layer_output_collector.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based frame model.
// Two instances share stimulus; the second uses a 2-bit drop counter to exercise saturation.
module tb_layer_output_collector;

    localparam int unsigned SIZE     = 3;
    localparam int unsigned BIT_SIZE = 16;
    localparam int unsigned DW       = SIZE * BIT_SIZE;

    logic                clk = 1'b0;
    logic                rst;
    logic                clear;
    logic                in_valid;
    logic [BIT_SIZE-1:0] y;
    logic                out_ready;

    logic                in_ready_a, out_valid_a;
    logic [DW-1:0]       out_data_a;
    logic [7:0]          drop_cnt_a;
    logic                in_ready_b, out_valid_b;
    logic [DW-1:0]       out_data_b;
    logic [1:0]          drop_cnt_b;

    layer_output_collector #(.SIZE(SIZE), .BIT_SIZE(BIT_SIZE), .DROP_W(8)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_a),
        .y(y), .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .drop_cnt(drop_cnt_a)
    );

    layer_output_collector #(.SIZE(SIZE), .BIT_SIZE(BIT_SIZE), .DROP_W(2)) dut_sat (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_b),
        .y(y), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .drop_cnt(drop_cnt_b)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: frame built as a queue of accepted words, plus the last-written image.
    bit                  m_hold;
    logic [BIT_SIZE-1:0] m_part[$];
    logic [BIT_SIZE-1:0] m_data[SIZE];
    int                  m_drop_a, m_drop_b;

    function automatic void model_reset();
        m_hold = 1'b0;
        m_part.delete();
        for (int k = 0; k < int'(SIZE); k++) m_data[k] = '0;
        m_drop_a = 0;
        m_drop_b = 0;
    endfunction

    function automatic bit model_ready(input logic ordy);
        return !m_hold || ordy;
    endfunction

    function automatic void model_step(input logic c, input logic iv, input logic [BIT_SIZE-1:0] w,
                                       input logic ordy);
        bit rdy;
        if (c) begin
            model_reset();
            return;
        end
        rdy = model_ready(ordy);
        if (iv && !rdy) begin
            if (m_drop_a < 255) m_drop_a++;
            if (m_drop_b < 3) m_drop_b++;
        end
        if (m_hold && ordy) m_hold = 1'b0;
        if (iv && rdy) begin
            m_data[m_part.size()] = w;
            m_part.push_back(w);
            if (m_part.size() == SIZE) begin
                m_hold = 1'b1;
                m_part.delete();
            end
        end
    endfunction

    function automatic logic [DW-1:0] model_data();
        logic [DW-1:0] r;
        for (int k = 0; k < int'(SIZE); k++) r[k*BIT_SIZE +: BIT_SIZE] = m_data[k];
        return r;
    endfunction

    task automatic check_outputs(input string tag);
        check_val({tag, ".out_valid"}, 64'(out_valid_a), 64'(m_hold));
        check_val({tag, ".out_data"}, 64'(out_data_a), 64'(model_data()));
        check_val({tag, ".drop_cnt"}, 64'(drop_cnt_a), 64'(m_drop_a));
        check_val({tag, ".sat_valid"}, 64'(out_valid_b), 64'(m_hold));
        check_val({tag, ".sat_drop"}, 64'(drop_cnt_b), 64'(m_drop_b));
    endtask

    int valid_pulses;

    // One clock: drive at negedge, check in_ready before the edge, step model, check after.
    task automatic cycle(input string tag, input logic c, input logic iv,
                         input logic [BIT_SIZE-1:0] w, input logic ordy);
        @(negedge clk);
        clear = c; in_valid = iv; y = w; out_ready = ordy;
        #1;
        check_val({tag, ".in_ready"}, 64'(in_ready_a), 64'(model_ready(ordy)));
        @(posedge clk);
        model_step(c, iv, w, ordy);
        #1;
        if (out_valid_a) valid_pulses++;
        check_outputs(tag);
    endtask

    initial begin
        rst = 1'b0; clear = 1'b0; in_valid = 1'b0; y = '0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("rst0");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("rst0.in_ready", 64'(in_ready_a), 64'd1);

        // T1: async reset mid-frame with two words stored.
        cycle("t1", 1'b0, 1'b1, 16'h1111, 1'b0);
        cycle("t1", 1'b0, 1'b1, 16'h2222, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_outputs("t1.async");
        check_val("t1.in_ready", 64'(in_ready_a), 64'd1);
        @(negedge clk);
        rst = 1'b1;

        // T2: single frame 5,-2,7 then held stable.
        cycle("t2", 1'b0, 1'b1, 16'd5, 1'b0);
        cycle("t2", 1'b0, 1'b1, 16'hFFFE, 1'b0);
        cycle("t2", 1'b0, 1'b1, 16'd7, 1'b0);
        check_val("t2.frame", 64'(out_data_a), 64'h0007_FFFE_0005);
        check_val("t2.valid", 64'(out_valid_a), 64'd1);
        repeat (10) cycle("t2.hold", 1'b0, 1'b0, 16'hDEAD, 1'b0);

        // T3: four drops during HOLD, then handoff with no new word.
        for (int i = 0; i < 4; i++) cycle("t3.drop", 1'b0, 1'b1, 16'(i + 100), 1'b0);
        check_val("t3.drop_cnt", 64'(drop_cnt_a), 64'd4);
        check_val("t3.frame", 64'(out_data_a), 64'h0007_FFFE_0005);
        cycle("t3.handoff", 1'b0, 1'b0, 16'h0, 1'b1);
        check_val("t3.valid", 64'(out_valid_a), 64'd0);

        // T4: 12 words streamed with out_ready held high.
        cycle("t4.clr", 1'b1, 1'b0, 16'h0, 1'b0);
        valid_pulses = 0;
        for (int i = 0; i < 12; i++) cycle("t4", 1'b0, 1'b1, 16'($urandom), 1'b1);
        cycle("t4.tail", 1'b0, 1'b0, 16'h0, 1'b1);
        check_val("t4.pulses", 64'(valid_pulses), 64'd4);
        check_val("t4.drop_cnt", 64'(drop_cnt_a), 64'd0);

        // T5: clear with a word offered discards partial frame and the word.
        cycle("t5", 1'b0, 1'b1, 16'h00AA, 1'b0);
        cycle("t5.clr", 1'b1, 1'b1, 16'h00BB, 1'b0);
        cycle("t5", 1'b0, 1'b1, 16'd1, 1'b0);
        cycle("t5", 1'b0, 1'b1, 16'd2, 1'b0);
        cycle("t5", 1'b0, 1'b1, 16'd3, 1'b0);
        check_val("t5.frame", 64'(out_data_a), 64'h0003_0002_0001);
        check_val("t5.drop_cnt", 64'(drop_cnt_a), 64'd0);

        // T6: six drops in HOLD saturate the 2-bit counter at 3.
        for (int i = 0; i < 6; i++) cycle("t6", 1'b0, 1'b1, 16'(i), 1'b0);
        check_val("t6.sat", 64'(drop_cnt_b), 64'd3);
        check_val("t6.wide", 64'(drop_cnt_a), 64'd6);

        // Random traffic with occasional clear.
        for (int i = 0; i < 400; i++) begin
            cycle("rnd", ($urandom_range(0, 39) == 0), $urandom_range(0, 3) != 0,
                  16'($urandom), $urandom_range(0, 2) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
